// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader: FSM encodings and field widths.
package uart_boot_pkg;
    localparam int         LEN_W         = 16;
    localparam int         CSUM_W        = 8;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_SYNC,
        L_LEN0,
        L_LEN1,
        L_DATA,
        L_CSUM,
        L_DONE,
        L_ERR
    } ld_state_t;
endpackage

// File: rtl/uart_boot_loader_if.sv
// TCM write port driven by the boot loader.
// mem_we_o is a one-cycle strobe with no back-pressure: the TCM must accept the
// word on every cycle mem_we_o is high; address and data hold between strobes.
interface uart_boot_loader_if #(
    parameter int MEM_AW = 14
);
    logic              mem_we_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;

    modport master (output mem_we_o, mem_addr_o, mem_wdata_o);
    modport slave  (input  mem_we_o, mem_addr_o, mem_wdata_o);
endinterface

// File: rtl/uart_boot_rx.sv
// UART byte receiver: 2-flop synchronizer, mid-bit sampling, LSB-first deserializer.
module uart_boot_rx
    import uart_boot_pkg::*;
#(
    parameter int BAUD_DIV = 16
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      rxd_i,
    output logic [7:0] byte_o,
    output logic      byte_vld_o,
    output logic      frm_err_o,
    output rx_state_t rx_state_o
);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);

    logic        sync1, sync2, rxd_prev;
    rx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        vld_d, err_d;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            rxd_prev   <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            byte_vld_o <= 1'b0;
            frm_err_o  <= 1'b0;
        end else begin
            sync1      <= rxd_i;
            sync2      <= sync1;
            rxd_prev   <= sync2;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            byte_vld_o <= vld_d;
            frm_err_o  <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxd_prev && !sync2) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    sh_d  = {sync2, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    vld_d   = sync2;
                    err_d   = !sync2;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o     = sh_q;
    assign rx_state_o = state_q;
endmodule

// File: rtl/uart_boot_loader.sv
// Receives a length-prefixed, XOR-checksummed program image over UART, writes it
// into the TCM and releases the core reset only once the image is verified.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int         BAUD_DIV  = 16,
    parameter int         MEM_AW    = 14,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      boot_en_i,
    input  logic      rxd_i,
    uart_boot_loader_if.master tcm,
    output logic      core_rstn_o,
    output logic      done_o,
    output logic      err_o,
    output ld_state_t ld_state_o,
    output rx_state_t rx_state_o
);
    localparam int unsigned LEN_MAX = 32'd1 << MEM_AW;

    logic [7:0] rx_byte;
    logic       rx_vld, rx_err;

    uart_boot_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .rxd_i      (rxd_i),
        .byte_o     (rx_byte),
        .byte_vld_o (rx_vld),
        .frm_err_o  (rx_err),
        .rx_state_o (rx_state_o)
    );

    ld_state_t          ld_q, ld_d;
    logic [CSUM_W-1:0]  csum_q, csum_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [MEM_AW:0]    widx_q, widx_d, widx_next;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        asm_q, asm_d;
    logic               started_q;
    logic               we_q, we_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ld_q        <= L_SYNC;
            csum_q      <= '0;
            bcnt_q      <= '0;
            widx_q      <= '0;
            len_q       <= '0;
            asm_q       <= '0;
            started_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_rstn_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            ld_q        <= ld_d;
            csum_q      <= csum_d;
            bcnt_q      <= bcnt_d;
            widx_q      <= widx_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            started_q   <= 1'b1;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            core_rstn_o <= (ld_d == L_DONE);
            done_o      <= (ld_d == L_DONE);
            err_o       <= (ld_d == L_ERR);
        end
    end

    assign widx_next = widx_q + {{MEM_AW{1'b0}}, 1'b1};

    always_comb begin
        ld_d    = ld_q;
        csum_d  = csum_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        len_d   = len_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (ld_q)
            L_SYNC: begin
                // boot_en_i only matters in the very first cycle out of reset.
                if (!started_q) begin
                    if (!boot_en_i) ld_d = L_DONE;
                end else if (rx_vld && rx_byte == SYNC_BYTE) begin
                    ld_d   = L_LEN0;
                    csum_d = '0;
                    bcnt_d = '0;
                    widx_d = '0;
                end
            end
            L_LEN0: begin
                if (rx_err) ld_d = L_ERR;
                else if (rx_vld) begin
                    len_d[7:0] = rx_byte;
                    csum_d     = csum_q ^ rx_byte;
                    ld_d       = L_LEN1;
                end
            end
            L_LEN1: begin
                if (rx_err) ld_d = L_ERR;
                else if (rx_vld) begin
                    len_d  = {rx_byte, len_q[7:0]};
                    csum_d = csum_q ^ rx_byte;
                    if (32'(len_d) > LEN_MAX) ld_d = L_ERR;
                    else if (len_d == '0)     ld_d = L_CSUM;
                    else                      ld_d = L_DATA;
                end
            end
            L_DATA: begin
                if (rx_err) ld_d = L_ERR;
                else if (rx_vld) begin
                    csum_d                    = csum_q ^ rx_byte;
                    asm_d[{bcnt_q, 3'b000} +: 8] = rx_byte;
                    bcnt_d                    = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = widx_q[MEM_AW-1:0];
                        wdata_d = {rx_byte, asm_q[23:0]};
                        widx_d  = widx_next;
                        if (32'(widx_next) == 32'(len_q)) ld_d = L_CSUM;
                    end
                end
            end
            L_CSUM: begin
                if (rx_err) ld_d = L_ERR;
                else if (rx_vld) ld_d = (rx_byte == csum_q) ? L_DONE : L_ERR;
            end
            L_DONE, L_ERR: ld_d = ld_q;
            default: ld_d = L_ERR;
        endcase
    end

    assign tcm.mem_we_o    = we_q;
    assign tcm.mem_addr_o  = addr_q;
    assign tcm.mem_wdata_o = wdata_q;
    assign ld_state_o      = ld_q;

    // The receiver emits either a byte or a framing error per frame, never both.
    a_vld_err_excl: assert property (@(posedge clk_i) disable iff (!rstn_i) !(rx_vld && rx_err));
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader with BAUD_DIV=8, MEM_AW=4.
module tb_uart_boot_loader;
    import uart_boot_pkg::*;

    localparam int BAUD = 8;
    localparam int AW   = 4;

    logic      clk = 1'b0;
    logic      rstn = 1'b0;
    logic      boot_en = 1'b1;
    logic      rxd = 1'b1;
    logic      core_rstn, done, err;
    ld_state_t ld_state;
    rx_state_t rx_state;

    uart_boot_loader_if #(.MEM_AW(AW)) tcm ();

    uart_boot_loader #(.BAUD_DIV(BAUD), .MEM_AW(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .boot_en_i   (boot_en),
        .rxd_i       (rxd),
        .tcm         (tcm),
        .core_rstn_o (core_rstn),
        .done_o      (done),
        .err_o       (err),
        .ld_state_o  (ld_state),
        .rx_state_o  (rx_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int we_double = 0;
    logic prev_we = 1'b0;

    logic [35:0] exp_q[$];
    logic [35:0] wr_q[$];
    logic [7:0]  tx_q[$];

    // write monitor
    always @(negedge clk) begin
        if (tcm.mem_we_o) begin
            if (prev_we) we_double++;
            wr_q.push_back({tcm.mem_addr_o, tcm.mem_wdata_o});
        end
        prev_we = tcm.mem_we_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    64'(tcm.mem_we_o),    64'd0);
        check({tag, "_addr"},  64'(tcm.mem_addr_o),  64'd0);
        check({tag, "_wdata"}, 64'(tcm.mem_wdata_o), 64'd0);
        check({tag, "_crst"},  64'(core_rstn),       64'd0);
        check({tag, "_done"},  64'(done),            64'd0);
        check({tag, "_err"},   64'(err),             64'd0);
    endtask

    task automatic check_status(input string tag, input logic d, input logic c, input logic e);
        check({tag, "_done"}, 64'(done),      64'(d));
        check({tag, "_crst"}, 64'(core_rstn), 64'(c));
        check({tag, "_err"},  64'(err),       64'(e));
    endtask

    // scoreboard: compare observed writes with the expected queue, then clear both
    task automatic check_writes(input string tag);
        int n;
        check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
        check({tag, "_we_width"}, 64'(we_double), 64'd0);
        wr_q.delete();
        exp_q.delete();
        we_double = 0;
    endtask

    task automatic apply_reset(input logic boot);
        rstn    = 1'b0;
        rxd     = 1'b1;
        boot_en = boot;
        tick(3);
        rstn = 1'b1;
        wr_q.delete();
        exp_q.delete();
        we_double = 0;
    endtask

    // driver: one UART frame, LSB first
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        tick(BAUD);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(BAUD);
        end
        rxd = stop;
        tick(BAUD);
        rxd = 1'b1;
        tick(4);
    endtask

    task automatic send_tx();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
    endtask

    task automatic nominal(input logic [7:0] cs);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88};
        tx_q.push_back(cs);
        send_tx();
    endtask

    initial begin
        // reset values
        rstn = 1'b0;
        tick(3);
        check_reset_vals("rst");
        check("rst_ld_state", 64'(ld_state), 64'(L_SYNC));
        rstn = 1'b1;
        tick(2);

        // nominal load, checksum 0x8A
        apply_reset(1'b1);
        tick(2);
        check_status("pre", 1'b0, 1'b0, 1'b0);
        nominal(8'h8A);
        exp_q.push_back({4'd0, 32'h44332211});
        exp_q.push_back({4'd1, 32'h88776655});
        check_writes("nom");
        check_status("nom", 1'b1, 1'b1, 1'b0);
        check("nom_ld_state", 64'(ld_state), 64'(L_DONE));
        send_byte(8'hA5, 1'b1);
        check("nom_ignore_wr", 64'(wr_q.size()), 64'd0);
        check_status("nom_ignore", 1'b1, 1'b1, 1'b0);

        // bad checksum
        apply_reset(1'b1);
        nominal(8'h8B);
        exp_q.push_back({4'd0, 32'h44332211});
        exp_q.push_back({4'd1, 32'h88776655});
        check_writes("badcs");
        check_status("badcs", 1'b0, 1'b0, 1'b1);

        // noise bytes and a short glitch before the frame
        apply_reset(1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        check("glitch_rx_state", 64'(rx_state), 64'(RX_IDLE));
        check("glitch_ld_state", 64'(ld_state), 64'(L_SYNC));
        nominal(8'h8A);
        exp_q.push_back({4'd0, 32'h44332211});
        exp_q.push_back({4'd1, 32'h88776655});
        check_writes("noise");
        check_status("noise", 1'b1, 1'b1, 1'b0);

        // framing error in the data phase
        apply_reset(1'b1);
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11};
        send_tx();
        send_byte(8'h22, 1'b0);
        tick(4);
        check_writes("frm");
        check_status("frm", 1'b0, 1'b0, 1'b1);

        // N = 16: maximum length, byte i of the payload is i
        apply_reset(1'b1);
        tx_q = '{8'hA5, 8'h10, 8'h00};
        for (int i = 0; i < 64; i++) tx_q.push_back(8'(i));
        tx_q.push_back(8'h10);
        for (int k = 0; k < 16; k++)
            exp_q.push_back({4'(k), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        send_tx();
        check_writes("n16");
        check_status("n16", 1'b1, 1'b1, 1'b0);

        // N = 17: too long, rejected after LEN1
        apply_reset(1'b1);
        tx_q = '{8'hA5, 8'h11, 8'h00};
        send_tx();
        check_status("n17", 1'b0, 1'b0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        check_writes("n17");

        // bypass
        apply_reset(1'b0);
        tick(3);
        check_status("byp", 1'b1, 1'b1, 1'b0);
        boot_en = 1'b1;
        nominal(8'h8A);
        check_writes("byp");

        // zero length
        apply_reset(1'b1);
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_tx();
        check_writes("n0");
        check_status("n0", 1'b1, 1'b1, 1'b0);

        // reset during word 1, then a full resend
        apply_reset(1'b1);
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_tx();
        exp_q.push_back({4'd0, 32'h44332211});
        check_writes("mid_w0");
        rxd = 1'b0;
        tick(BAUD);
        rxd = 1'b0;
        tick(BAUD + 3);
        rstn = 1'b0;
        rxd  = 1'b1;
        tick(1);
        check_reset_vals("mid");
        rstn = 1'b1;
        tick(30);
        wr_q.delete();
        we_double = 0;
        check_status("mid_idle", 1'b0, 1'b0, 1'b0);
        nominal(8'h8A);
        exp_q.push_back({4'd0, 32'h44332211});
        exp_q.push_back({4'd1, 32'h88776655});
        check_writes("resend");
        check_status("resend", 1'b1, 1'b1, 1'b0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
